// File: rtl/spi_slave_responder.sv
// spi_slave_responder
// SPI slave endpoint. All SPI pins are oversampled in the clk_i domain
// (2-flop synchronisers plus one edge-detect register for SCK and SS).
// Bytes are received MSB first on rx_data_o. Bytes to send come from a
// one-entry transmit buffer, and IDLE_BYTE is sent when that buffer is empty.
//
// Optional feature macro: SPI_SLAVE_OVR_EN
//   undefined : rx_valid_o is a one-cycle strobe, no receive flow control.
//   defined   : rx_valid_o is held until rx_ready_i, a byte completing while
//               rx_valid_o is high sets a sticky rx_overrun_o, and ovr_clr_i
//               clears it (a coincident set wins).
//
// Ports
//   clk_i, rst_ni      system clock (>= 8x SCK), asynchronous active-low reset
//   cpol_i, cpha_i     SPI mode, static while ss_ni is high
//   sck_i, ss_ni       serial clock and active-low select (asynchronous)
//   mosi_i / miso_o    serial data in / out, miso_oe_o high while selected
//   tx_data_i/_valid_i transmit byte offered. It is accepted when tx_ready_o is high.
//   tx_ready_o         transmit buffer empty
//   tx_underrun_o      pulse: IDLE_BYTE was loaded because the buffer was empty
//   rx_data_o/_valid_o last completed received byte and its strobe
//   state_o            debug view of the FSM state (0 idle, 1 active)
//
// Handshake: a transmit byte transfers on any clk_i cycle where tx_valid_i and
// tx_ready_o are both high. With SPI_SLAVE_OVR_EN, a received byte is consumed
// on any cycle where rx_valid_o and rx_ready_i are both high.
module spi_slave_responder #(
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       sck_i,
  input  logic       ss_ni,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
`ifdef SPI_SLAVE_OVR_EN
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  input  logic       ovr_clr_i,
`endif
  output logic       state_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;

  state_e     state_q, state_d;
  logic       sck_s1_q, sck_s2_q, sck_s3_q;
  logic       ss_s1_q, ss_s2_q, ss_s3_q;
  logic       mosi_s1_q, mosi_s2_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;
  logic       underrun_q, underrun_d;
  logic       miso_q;
`ifdef SPI_SLAVE_OVR_EN
  logic       overrun_q, overrun_d;
`endif

  // Edge detection compares the second and third synchroniser stages.
  // Each internal event therefore takes effect 3 clk_i cycles after the pin edge.
  logic sck_rise, sck_fall, ss_fall, ss_rise;
  logic lead_edge, trail_edge, active, enter, sample_evt, shift_evt, load;

  assign sck_rise   = sck_s2_q & ~sck_s3_q;
  assign sck_fall   = ~sck_s2_q & sck_s3_q;
  assign ss_fall    = ~ss_s2_q & ss_s3_q;
  assign ss_rise    = ss_s2_q & ~ss_s3_q;
  assign lead_edge  = cpol_i ? sck_fall : sck_rise;
  assign trail_edge = cpol_i ? sck_rise : sck_fall;
  assign active     = (state_q == ST_ACTIVE);
  assign enter      = (state_q == ST_IDLE) && ss_fall;
  // SCK edges are ignored while idle and in the cycle the frame ends.
  assign sample_evt = active && !ss_rise && (cpha_i ? trail_edge : lead_edge);
  assign shift_evt  = active && !ss_rise && (cpha_i ? lead_edge : trail_edge);
  // A shift edge seen with the counter at 0 starts a new byte. For CPHA=0 this
  // is the shift edge right after the 8th sample. For CPHA=1 it is the first
  // shift edge of each byte. CPHA=0 also loads at frame entry so that bit 7 is
  // already on miso before the first sample edge.
  assign load       = (enter && !cpha_i) || (shift_evt && bit_cnt_q == 3'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_s1_q  <= 1'b0; sck_s2_q  <= 1'b0; sck_s3_q <= 1'b0;
      ss_s1_q   <= 1'b0; ss_s2_q   <= 1'b0; ss_s3_q  <= 1'b0;
      mosi_s1_q <= 1'b0; mosi_s2_q <= 1'b0;
    end else begin
      sck_s1_q  <= sck_i;     sck_s2_q  <= sck_s1_q; sck_s3_q <= sck_s2_q;
      ss_s1_q   <= ss_ni;     ss_s2_q   <= ss_s1_q;  ss_s3_q  <= ss_s2_q;
      mosi_s1_q <= mosi_i;    mosi_s2_q <= mosi_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ss_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (ss_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
`ifdef SPI_SLAVE_OVR_EN
    rx_valid_d = rx_valid_q & ~rx_ready_i;
    overrun_d  = ovr_clr_i ? 1'b0 : overrun_q;
`else
    rx_valid_d = 1'b0;
`endif
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    underrun_d = 1'b0;

    // A partial byte is simply dropped, because the counter restarts on entry.
    if (enter || (active && ss_rise)) bit_cnt_d = 3'd0;

    if (sample_evt) begin
      rx_shift_d = {rx_shift_q[6:0], mosi_s2_q};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d  = {rx_shift_q[6:0], mosi_s2_q};
        rx_valid_d = 1'b1;
`ifdef SPI_SLAVE_OVR_EN
        if (rx_valid_q) overrun_d = 1'b1;
`endif
      end
    end

    if (load) begin
      tx_shift_d = tx_full_q ? tx_buf_q : IDLE_BYTE;
      underrun_d = ~tx_full_q;
      tx_full_d  = 1'b0;
    end else if (shift_evt) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end

    // Accepting in a load cycle with an empty buffer keeps the new byte for the
    // next load, because IDLE_BYTE was already chosen above.
    if (tx_valid_i && !tx_full_q) begin
      tx_buf_d  = tx_data_i;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_shift_q <= 8'h00;
      tx_buf_q   <= 8'h00;
      tx_full_q  <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
`ifdef SPI_SLAVE_OVR_EN
      overrun_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      underrun_q <= underrun_d;
      miso_q     <= tx_shift_q[7];
`ifdef SPI_SLAVE_OVR_EN
      overrun_q  <= overrun_d;
`endif
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = active;
  assign tx_ready_o    = ~tx_full_q;
  assign tx_underrun_o = underrun_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign state_o       = logic'(state_q);
`ifdef SPI_SLAVE_OVR_EN
  assign rx_overrun_o  = overrun_q;
`endif

endmodule
